// File: rtl/frame_fetch_sequencer.sv
// Fetches a width x height frame of 32-bit pixels one line per burst-read command
// and streams the master's user buffer out as valid/ready pixels with sof/eol/eof markers.
module frame_fetch_sequencer #(
    parameter int DIM_W  = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic [ADDR_W-1:0] stride,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    output logic              busy,
    output logic              frame_done,
    output logic              aborted,
    output logic [DIM_W-1:0]  cur_line,
    output logic              mm_fixed_location,
    output logic [ADDR_W-1:0] mm_read_base,
    output logic [31:0]       mm_read_length,
    output logic              mm_go,
    input  logic              mm_done,
    output logic              mm_read_buffer,
    input  logic [31:0]       mm_buffer_data,
    input  logic              mm_data_available,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic [2:0]        state_dbg
);

    // Pixel handshake: a word moves in every cycle where out_valid and out_ready are
    // both high; out_valid never depends on out_ready and the buffer head is popped
    // in exactly those cycles.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        GO     = 3'd2,
        STREAM = 3'd3,
        NEXT   = 3'd4,
        DRAIN  = 3'd5
    } state_t;

    localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

    state_t              state, state_nxt;
    logic [DIM_W-1:0]    width_r, height_r, line, word_cnt;
    logic [ADDR_W-1:0]   stride_r, addr;
    logic                done_seen, go_d;
    logic                frame_done_nxt, aborted_nxt, accept;
    logic                line_full, last_line;

    assign line_full         = (word_cnt == width_r);
    assign last_line         = (line == height_r - ONE);
    assign busy              = (state != IDLE);
    assign cur_line          = line;
    assign mm_fixed_location = 1'b0;
    assign out_data          = mm_buffer_data;
    assign state_dbg         = state;

    always_comb begin
        state_nxt      = state;
        frame_done_nxt = 1'b0;
        aborted_nxt    = 1'b0;
        accept         = 1'b0;
        mm_go          = 1'b0;
        out_valid      = 1'b0;
        mm_read_buffer = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (width == '0 || height == '0) begin
                        frame_done_nxt = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = SETUP;
                    end
                end
            end
            SETUP: begin
                state_nxt   = abort ? IDLE : GO;
                aborted_nxt = abort;
            end
            GO: begin
                mm_go     = 1'b1;
                state_nxt = abort ? DRAIN : STREAM;
            end
            STREAM: begin
                out_valid      = mm_data_available && !line_full;
                mm_read_buffer = out_valid && out_ready;
                if (abort)
                    state_nxt = DRAIN;
                else if (line_full && done_seen)
                    state_nxt = NEXT;
            end
            NEXT: begin
                if (abort) begin
                    state_nxt   = IDLE;
                    aborted_nxt = 1'b1;
                end else if (last_line) begin
                    state_nxt      = IDLE;
                    frame_done_nxt = 1'b1;
                end else begin
                    state_nxt = SETUP;
                end
            end
            DRAIN: begin
                // The issued burst must be consumed so the master is left empty.
                mm_read_buffer = mm_data_available && !line_full;
                if (line_full && done_seen) begin
                    state_nxt   = IDLE;
                    aborted_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_sof = out_valid && (line == '0) && (word_cnt == '0);
    assign out_eol = out_valid && (word_cnt == width_r - ONE);
    assign out_eof = out_eol && last_line;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            frame_done     <= 1'b0;
            aborted        <= 1'b0;
            width_r        <= '0;
            height_r       <= '0;
            stride_r       <= '0;
            addr           <= '0;
            line           <= '0;
            word_cnt       <= '0;
            done_seen      <= 1'b0;
            go_d           <= 1'b0;
            mm_read_base   <= '0;
            mm_read_length <= '0;
        end else begin
            state      <= state_nxt;
            frame_done <= frame_done_nxt;
            aborted    <= aborted_nxt;
            go_d       <= (state == GO);
            if (accept) begin
                width_r  <= width;
                height_r <= height;
                stride_r <= stride;
                addr     <= frame_base;
                line     <= '0;
            end
            if (state == SETUP) begin
                mm_read_base   <= addr;
                mm_read_length <= 32'({width_r, 2'b00});
                word_cnt       <= '0;
                done_seen      <= 1'b0;
            end else begin
                if (mm_read_buffer)
                    word_cnt <= word_cnt + ONE;
                // A done level left over from the previous burst is not trusted
                // until two cycles after the command strobe.
                if ((state == STREAM || state == DRAIN) && !go_d && mm_done)
                    done_seen <= 1'b1;
            end
            if (state == NEXT && !abort && !last_line) begin
                line <= line + ONE;
                addr <= addr + stride_r;
            end
        end
    end

endmodule

// File: tb/tb_frame_fetch_sequencer.sv
// Bench for frame_fetch_sequencer: a burst-master model feeds the show-ahead buffer
// while a scoreboard checks commands, pixels, markers and status pulses.
module tb_frame_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] frame_base = '0;
    logic [31:0] stride = '0;
    logic [15:0] width = '0;
    logic [15:0] height = '0;
    logic        busy, frame_done, aborted;
    logic [15:0] cur_line;
    logic        mm_fixed_location;
    logic [31:0] mm_read_base, mm_read_length;
    logic        mm_go;
    logic        mm_done;
    logic        mm_read_buffer;
    logic [31:0] mm_buffer_data;
    logic        mm_data_available;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sof, out_eol, out_eof;
    logic [2:0]  state_dbg;

    frame_fetch_sequencer #(.DIM_W(16), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .frame_base(frame_base), .stride(stride), .width(width), .height(height),
        .busy(busy), .frame_done(frame_done), .aborted(aborted), .cur_line(cur_line),
        .mm_fixed_location(mm_fixed_location), .mm_read_base(mm_read_base),
        .mm_read_length(mm_read_length), .mm_go(mm_go), .mm_done(mm_done),
        .mm_read_buffer(mm_read_buffer), .mm_buffer_data(mm_buffer_data),
        .mm_data_available(mm_data_available), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
        .out_eol(out_eol), .out_eof(out_eof), .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int n_total = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard queues: pixels {sof,eol,eof,data} and commands {base,length}
    logic [34:0] exp_q[$];
    logic [63:0] cmd_q[$];
    int n_go, n_fd, n_ab, n_pop, n_drain;

    // master model configuration
    bit gap_mode = 0;
    bit ready_toggle = 0;
    bit hold_mode = 0;
    bit early_mode = 0;
    int done_lag = 0;

    logic [31:0] buf_q[$];
    int          pend = 0;
    int          gap = 0;
    int          lag = 0;
    bit          hold_left = 0;
    logic        mdone_r = 1'b1;
    logic [31:0] addr_n = '0;
    logic        avail_r = 1'b0;
    logic [31:0] data_r = '0;

    assign mm_done           = mdone_r;
    assign mm_data_available = avail_r;
    assign mm_buffer_data    = data_r;

    always @(posedge clk) begin
        logic        pop_s, go_s;
        logic [31:0] rb_s, rl_s;
        logic [63:0] c;
        pop_s = mm_read_buffer;
        go_s  = mm_go;
        rb_s  = mm_read_base;
        rl_s  = mm_read_length;
        #1;
        if (reset) begin
            buf_q.delete();
            pend = 0; gap = 0; lag = 0; hold_left = 0;
            mdone_r = 1'b1;
            out_ready = 1'b1;
        end else begin
            if (pop_s) begin
                if (buf_q.size() == 0) check("pop_empty", 1, 0);
                else void'(buf_q.pop_front());
            end
            if (go_s) begin
                check("go_idle", {pend == 0, buf_q.size() == 0, mdone_r}, 3'b111);
                if (cmd_q.size() == 0) begin
                    check("go_extra", 1, 0);
                end else begin
                    c = cmd_q.pop_front();
                    check("rd_base", rb_s, c[63:32]);
                    check("rd_len", rl_s, c[31:0]);
                end
                pend = int'(rl_s >> 2);
                addr_n = rb_s;
                hold_left = hold_mode;
                mdone_r = hold_mode;
                lag = done_lag;
                gap = 0;
            end else begin
                if (pend > 0) begin
                    if (gap == 0) begin
                        buf_q.push_back(addr_n);
                        addr_n = addr_n + 32'd4;
                        pend--;
                        gap = gap_mode ? 5 : 0;
                    end else begin
                        gap--;
                    end
                end
                if (hold_left) begin
                    hold_left = 0;
                    mdone_r = 1'b0;
                end else if (!mdone_r) begin
                    if (early_mode && pend <= 1) mdone_r = 1'b1;
                    else if (pend == 0) begin
                        if (lag == 0) mdone_r = 1'b1;
                        else lag--;
                    end
                end
            end
            out_ready = ready_toggle ? ~out_ready : 1'b1;
        end
        avail_r = (buf_q.size() != 0);
        data_r  = (buf_q.size() != 0) ? buf_q[0] : 32'd0;
    end

    // output monitor
    always @(negedge clk) begin
        logic [34:0] e;
        if (!reset) begin
            if (mm_go) n_go++;
            if (frame_done) n_fd++;
            if (aborted) n_ab++;
            if (mm_read_buffer) n_pop++;
            if (mm_read_buffer && !out_valid) n_drain++;
            if (out_valid) check("rd_strobe", mm_read_buffer, out_ready);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("px_extra", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", {out_sof, out_eol, out_eof, out_data}, e);
                end
            end
        end
    end

    // driver tasks
    task automatic build_exp(input logic [31:0] base, input logic [31:0] strd,
                             input logic [15:0] w, input logic [15:0] h,
                             input int ab_line, input int ab_pix);
        int last_l;
        logic [31:0] a;
        exp_q.delete();
        cmd_q.delete();
        last_l = (ab_line >= 0) ? ab_line : int'(h) - 1;
        for (int l = 0; l <= last_l; l++) begin
            cmd_q.push_back({base + 32'(l) * strd, 32'(w) * 32'd4});
            for (int p = 0; p < int'(w); p++) begin
                if (ab_line >= 0 && l == ab_line && p > ab_pix) break;
                a = base + 32'(l) * strd + 32'(p) * 32'd4;
                exp_q.push_back({(l == 0 && p == 0), (p == int'(w) - 1),
                                 (p == int'(w) - 1 && l == int'(h) - 1), a});
            end
        end
        n_go = 0; n_fd = 0; n_ab = 0; n_pop = 0; n_drain = 0;
    endtask

    task automatic run_frame(input logic [31:0] base, input logic [31:0] strd,
                             input logic [15:0] w, input logic [15:0] h,
                             input int ab_line, input int ab_pix);
        int budget;
        int last_l;
        logic [31:0] ab_addr;
        build_exp(base, strd, w, h, ab_line, ab_pix);
        last_l = (ab_line >= 0) ? ab_line : int'(h) - 1;
        ab_addr = base + 32'(ab_line) * strd + 32'(ab_pix) * 32'd4;
        frame_base = base; stride = strd; width = w; height = h;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_on", busy, 1);
        for (budget = 0; budget < 4000; budget++) begin
            abort = 1'b0;
            if (ab_line >= 0 && out_valid && out_ready && out_data == ab_addr) abort = 1'b1;
            if (n_fd + n_ab > 0) break;
            @(negedge clk);
        end
        abort = 1'b0;
        check("frame_timeout", budget < 4000, 1);
        repeat (12) @(negedge clk);
        check("exp_left", exp_q.size(), 0);
        check("cmd_left", cmd_q.size(), 0);
        check("go_count", n_go, last_l + 1);
        check("done_count", n_fd, (ab_line >= 0) ? 0 : 1);
        check("abort_count", n_ab, (ab_line >= 0) ? 1 : 0);
        check("pop_count", n_pop, (last_l + 1) * int'(w));
        check("drain_pops", n_drain, (ab_line >= 0) ? int'(w) - ab_pix - 1 : 0);
        check("busy_off", busy, 0);
    endtask

    task automatic zero_frame(input logic [15:0] w, input logic [15:0] h);
        build_exp(32'h500, 32'h10, w, h, -1, -1);
        cmd_q.delete();
        width = w; height = h; frame_base = 32'h500;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_fd", frame_done, 1);
        check("zero_busy", busy, 0);
        @(negedge clk);
        check("zero_fd_pulse", frame_done, 0);
        repeat (5) @(negedge clk);
        check("zero_go", n_go, 0);
        check("zero_fd_count", n_fd, 1);
        check("zero_busy_end", busy, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pulses"}, {frame_done, aborted, mm_go}, 0);
        check({tag, "_stream"}, {out_valid, mm_read_buffer, out_sof, out_eol, out_eof}, 0);
        check({tag, "_line"}, cur_line, 0);
        check({tag, "_cmd"}, {mm_read_base, mm_read_length}, 0);
        check({tag, "_fixed"}, mm_fixed_location, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    initial begin
        bit found;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst");

        run_frame(32'h1000, 32'h100, 16'd4, 16'd3, -1, -1);

        ready_toggle = 1; gap_mode = 1;
        run_frame(32'h1000, 32'h100, 16'd4, 16'd3, -1, -1);
        ready_toggle = 0; gap_mode = 0;
        repeat (2) @(negedge clk);

        zero_frame(16'd0, 16'd3);
        zero_frame(16'd5, 16'd0);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", {busy, aborted}, 0);

        run_frame(32'h2000, 32'h40, 16'd8, 16'd4, 1, 1);

        hold_mode = 1; done_lag = 3;
        run_frame(32'h3000, 32'h20, 16'd4, 16'd3, -1, -1);
        hold_mode = 0; done_lag = 0;
        early_mode = 1; gap_mode = 1; ready_toggle = 1;
        run_frame(32'h4000, 32'h10, 16'd4, 16'd2, -1, -1);
        early_mode = 0; gap_mode = 0; ready_toggle = 0;
        repeat (2) @(negedge clk);

        run_frame(32'hFFFF_FF80, 32'h40, 16'd4, 16'd3, -1, -1);

        build_exp(32'h1000, 32'h100, 16'd4, 16'd3, -1, -1);
        frame_base = 32'h1000; stride = 32'h100; width = 16'd4; height = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 500; i++) begin
            if (cur_line == 16'd1 && out_valid) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("reach_line1", found, 1);
        #2 reset = 1'b1;
        #1 check_idle_outputs("async_rst");
        exp_q.delete();
        cmd_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_frame(32'h1000, 32'h100, 16'd4, 16'd3, -1, -1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
